// File: rtl/ram_sp_clr_pkg.sv
// ram_sp_clr_pkg: shared FSM state type, even-parity helper and default sizes for ram_sp_clr
package ram_sp_clr_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int PAR_MAX_W = 64;
  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  // Zero-extension leaves parity unchanged, so one wide version serves any width up to PAR_MAX_W.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/ram_sp_clr_if.sv
// ram_sp_clr_if: cs/wr access bus of ram_sp_clr; RAM_SP_CLR_PARITY_EN adds err_inj/par_err
interface ram_sp_clr_if import ram_sp_clr_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic cs, wr, clr_req, ready, rd_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in, data_out;
`ifdef RAM_SP_CLR_PARITY_EN
  logic err_inj, par_err;
  modport master(output cs, wr, addr, data_in, clr_req, err_inj, input ready, data_out, rd_valid, par_err);
  modport slave(input cs, wr, addr, data_in, clr_req, err_inj, output ready, data_out, rd_valid, par_err);
`else
  modport master(output cs, wr, addr, data_in, clr_req, input ready, data_out, rd_valid);
  modport slave(input cs, wr, addr, data_in, clr_req, output ready, data_out, rd_valid);
`endif
endinterface

// File: rtl/ram_sp_array.sv
// ram_sp_array: plain single-port storage, synchronous write, read data registered by the caller
module ram_sp_array #(
  parameter int W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [W-1:0]      wdata_i,
  output logic [W-1:0]      rdata_o
);
  logic [W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: single-port RAM with clear sweep, registered read + rd_valid; RAM_SP_CLR_PARITY_EN adds per-word parity
module ram_sp_clr import ram_sp_clr_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  ram_sp_clr_if.slave bus
);
`ifdef RAM_SP_CLR_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, mem_addr;
  logic ready_q, ready_d, rd_valid_q, rd_valid_d, mem_we, acc;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [W-1:0] mem_wdata, mem_rdata, wr_word, clr_word;
`ifdef RAM_SP_CLR_PARITY_EN
  logic par_err_q, par_err_d;
  // Stored bit is the even parity of the data, inverted on request to model a corrupted word.
  assign wr_word = {even_par(PAR_MAX_W'(bus.data_in)) ^ bus.err_inj, bus.data_in};
  assign clr_word = {even_par(PAR_MAX_W'(CLR_VAL)), CLR_VAL};
  assign par_err_d = rd_valid_d && (mem_rdata[DATA_W] != even_par(PAR_MAX_W'(mem_rdata[DATA_W-1:0])));
  assign bus.par_err = par_err_q;
`else
  assign wr_word = bus.data_in;
  assign clr_word = CLR_VAL;
`endif
  always_comb begin
    acc = state_q == ST_READY && bus.cs && !bus.clr_req;
    mem_we = state_q == ST_CLEAR || (acc && bus.wr);
    mem_addr = state_q == ST_CLEAR ? ptr_q : bus.addr;
    mem_wdata = state_q == ST_CLEAR ? clr_word : wr_word;
    state_d = state_q == ST_CLEAR ? (&ptr_q ? ST_READY : ST_CLEAR) : (bus.clr_req ? ST_CLEAR : ST_READY);
    ptr_d = state_q == ST_CLEAR ? ptr_q + 1'b1 : '0;
    ready_d = state_d == ST_READY;
    rd_valid_d = acc && !bus.wr;
    data_out_d = rd_valid_d ? mem_rdata[DATA_W-1:0] : data_out_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q <= '0;
      ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
`ifdef RAM_SP_CLR_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      ready_q <= ready_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
`ifdef RAM_SP_CLR_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  ram_sp_array #(.W(W), .ADDR_W(ADDR_W)) u_array (
    .clk(clk),
    .we_i(mem_we),
    .addr_i(mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );
  assign bus.ready = ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: randomized scoreboard bench for ram_sp_clr against an array-level reference model
module tb_ram_sp_clr;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  typedef struct {logic [DW-1:0] d; logic pe;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  ram_sp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .CLR_VAL(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vectors = 0;
  int errors = 0;
  logic [DW-1:0] m_mem [DEPTH];
  bit m_bad [DEPTH];
  bit m_ready = 1'b0;
  int clr_left = DEPTH;
  logic [DW-1:0] m_dout = '0;
  exp_t sbq[$];
  exp_t x;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask
  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
    clr_left = DEPTH;
    m_ready = 1'b0;
  endtask
  task automatic apply(input bit c, input bit w, input int a, input int d, input bit cl, input bit e);
    bus.cs = c;
    bus.wr = w;
    bus.addr = AW'(a);
    bus.data_in = DW'(d);
    bus.clr_req = cl;
`ifdef RAM_SP_CLR_PARITY_EN
    bus.err_inj = e;
`endif
    if (m_ready) begin
      if (cl) m_clear();
      else if (c && w) begin
        m_mem[a % DEPTH] = DW'(d);
        m_bad[a % DEPTH] = e;
      end else if (c) sbq.push_back('{m_mem[a % DEPTH], m_bad[a % DEPTH]});
    end else begin
      clr_left--;
      if (clr_left == 0) m_ready = 1'b1;
    end
  endtask
  task automatic step(input bit c, input bit w, input int a, input int d, input bit cl, input bit e);
    @(negedge clk);
    apply(c, w, a, d, cl, e);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, int'($urandom_range(DEPTH - 1)), int'($urandom_range(255)), 1'b0, 1'b0);
  endtask
  task automatic wr(input int a, input int d, input bit e);
    step(1'b1, 1'b1, a, d, 1'b0, e);
  endtask
  task automatic rd(input int a);
    step(1'b1, 1'b0, a, int'($urandom_range(255)), 1'b0, 1'b0);
  endtask
  task automatic rst_assert();
    rst_n = 1'b0;
    #1;
    sbq.delete();
    m_dout = '0;
    m_clear();
    check("rst_ready", bus.ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_data_out", bus.data_out, 0);
  endtask
  task automatic rst_release(input int n);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic wait_ready();
    while (!m_ready) idle();
  endtask
  // Every read issued before an edge must come back on exactly that edge.
  always begin
    @(posedge clk);
    #1;
    check("ready", bus.ready, m_ready);
    if (bus.rd_valid) begin
      check("rd_expected", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        x = sbq.pop_front();
        check("rd_data", bus.data_out, x.d);
`ifdef RAM_SP_CLR_PARITY_EN
        check("par_err", bus.par_err, x.pe);
`endif
        m_dout = x.d;
      end
    end else begin
      check("data_hold", bus.data_out, m_dout);
`ifdef RAM_SP_CLR_PARITY_EN
      check("par_err_idle", bus.par_err, 0);
`endif
    end
    check("rd_latency_pending", sbq.size(), 0);
    sbq.delete();
  end
  initial begin
    bus.cs = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;
    bus.clr_req = 1'b0;
`ifdef RAM_SP_CLR_PARITY_EN
    bus.err_inj = 1'b0;
`endif
    #1;
    rst_assert();
    rst_release(3);
    wait_ready();
    rd(0);
    rd(511);
    rd(1023);
    idle();
    for (int i = 0; i < DEPTH; i++) wr(i, (i * 3) % 256, 1'b0);
    repeat (20) rd(int'($urandom_range(DEPTH - 1)));
    idle();
    wr(5, 8'hA5, 1'b0);
    rd(5);
    rd(6);
    idle();
    step(1'b1, 1'b1, 7, 8'h33, 1'b1, 1'b0);
    while (!m_ready)
      step(1'b1, 1'($urandom_range(1)), 7 + int'($urandom_range(1)), 8'h55, 1'($urandom_range(1)), 1'b0);
    rd(7);
    rd(8);
    idle();
    step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    repeat (300) idle();
    @(negedge clk);
    rst_assert();
    rst_release(3);
    wait_ready();
    rd(0);
    rd(300);
    idle();
`ifdef RAM_SP_CLR_PARITY_EN
    wr(9, 8'h0F, 1'b1);
    rd(9);
    wr(9, 8'h0F, 1'b0);
    rd(9);
    idle();
`endif
    repeat (600) begin
      case ($urandom_range(3))
        0: idle();
        1: wr(int'($urandom_range(DEPTH - 1)), int'($urandom_range(255)), 1'($urandom_range(1)));
        default: rd(int'($urandom_range(DEPTH - 1)));
      endcase
    end
    repeat (3) idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
Parametrised single-port synchronous RAM, successor to the 1024x8 chip-select RAM. Adds a registered read with a valid strobe, a ready handshake, and a hardware clear sequencer. After reset, or on request, the clear sequencer sweeps every location to CLR_VAL. Used as local scratch storage behind simple cs/wr masters.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
CLR_VAL, 0, value written to every word during a clear sweep (DATA_W bits)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  access request, sampled on rising clk
wr  in  1  1 = write, 0 = read; qualified by cs
addr  in  ADDR_W  word address
data_in  in  DATA_W  write data
clr_req  in  1  single-cycle pulse that starts a full clear sweep
ready  out  1  1 = accesses accepted; 0 = clear sweep in progress
data_out  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse marking data_out as updated

Behaviour:
- Reset is asynchronous and active-low (rst_n). One clock (clk).
- While rst_n=0: ready=0, rd_valid=0, data_out=0, clear pointer=0, FSM=CLEAR. Array contents are not reset directly; they are cleared by the sweep.
- FSM states: CLEAR and READY.
- CLEAR state:
  - Each cycle writes CLR_VAL to mem[ptr], then ptr increments.
  - At ptr = DEPTH-1 the write completes, FSM goes to READY, and ptr wraps to 0.
  - Sweep length is exactly DEPTH cycles. ready rises on the cycle after the last clear write.
- READY state:
  - Access accepted on a rising edge when cs=1.
  - Write (wr=1): mem[addr] <= data_in on that edge. No rd_valid. data_out unchanged.
  - Read (wr=0): data_out <= mem[addr] on that edge, and rd_valid=1 for that one cycle. Latency is 1 cycle.
  - Back-to-back reads on consecutive cycles are allowed; rd_valid stays high continuously.
  - cs=0: no access, rd_valid=0, data_out holds its last value.
- Accesses with cs=1 while ready=0 are ignored: no write, no rd_valid. The master must wait for ready.
- clr_req in READY: the same edge enters CLEAR with ptr=0, and any simultaneous cs access is dropped.
- clr_req in CLEAR is ignored; the sweep does not restart.
- A read immediately after a write to the same address returns the newly written data.
- rst_n asserted mid-sweep or mid-access aborts it immediately. On release, the sweep restarts from 0.
- data_out is never X after reset. It reads 0 until the first read.

Optional Feature:
Macro RAM_SP_CLR_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed on write. The clear sweep writes the parity of CLR_VAL.
  - Added input err_inj (1 bit): a write with err_inj=1 stores inverted parity.
  - Added output par_err (1 bit, reset 0): pulses together with rd_valid when the recomputed parity of the read word mismatches the stored bit.
- Undefined: no parity storage, and neither err_inj nor par_err exists on the port list.

Decomposition:
- Package ram_sp_clr_pkg holds:
  - the state enum (ST_CLEAR, ST_READY);
  - the even-parity function, generic over width;
  - the default width constants.
- Sub-module ram_sp_array holds the storage: plain synchronous write/read array with width DATA_W (+1 when parity is enabled) and depth DEPTH.
- ram_sp_clr holds the FSM, pointer, muxing and output registers.

Test Plan:
1. Reset release with defaults: ready=0 for exactly 1024 cycles, then 1; reads of addr 0, 511 and 1023 return 0x00 with rd_valid one cycle later.
2. Write sweep: data (i*3)%256 to addr i for all 1024 addresses, then 20 random-address reads; each returns (addr*3)%256 with rd_valid=1 and latency 1.
3. Write 0xA5 to addr 5, then read addr 5 on the next cycle: data_out=0xA5. Back-to-back reads of addr 5 and 6 give rd_valid high for two consecutive cycles.
4. clr_req pulse with a concurrent write of 0x33 to addr 7: ready=0 for 1024 cycles; afterwards addr 7 reads 0x00. cs pulses during the sweep produce no rd_valid and no writes.
5. rst_n low at sweep cycle 300 for 3 cycles: outputs go to 0 immediately; after release, ready rises after a full 1024 cycles.
6. With RAM_SP_CLR_PARITY_EN: write 0x0F to addr 9 with err_inj=1 and read it back: par_err=1 with rd_valid. Write 0x0F without err_inj and read it back: par_err=0.
